i2c_bus_arbiter: RTL and testbench
==================================

Name: i2c_bus_arbiter

Overview:
- Shares one I2C byte engine (START/byte/ACK/STOP primitive, slave address 0x7A display path) between N byte-stream requesters, e.g. the init-command sequencer and the frame-buffer streamer.
- Round-robin arbitration per transaction. Each transaction is: START + slave address, N data bytes, STOP.
- Handles slave NACK and stall timeouts by aborting with STOP and reporting an error to the granted requester.

Parameters:
- N, 2, number of requesters (2..8).
- SLAVE_ADDR, 8'h7A, address byte sent with START (R/W bit included).
- GAP_CYC, 4, idle cycles enforced after each STOP before the next arbitration (1..255).
- TIMEOUT, 1023, max cycles waiting in any DATA/ACK state before abort.

Ports:
- clk2  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous active-low reset.
- req  in  N  per-requester transaction request; sampled only in IDLE.
- gnt  out  N  one-hot grant; held from ARB through GAP.
- req_data  in  8N  byte from requester i at [8i+7:8i].
- req_valid  in  N  requester byte valid.
- req_last  in  N  qualifies req_data as the final byte of the transaction.
- req_ready  out  N  byte accepted when req_valid & req_ready.
- req_done  out  N  1-cycle pulse: transaction completed with all bytes ACKed.
- req_err  out  N  1-cycle pulse: transaction aborted (NACK or timeout).
- eng_valid  out  1  command to engine valid.
- eng_start  out  1  qualifies command: generate START before eng_data.
- eng_stop  out  1  qualifies command: STOP only; eng_data ignored.
- eng_data  out  8  byte to transmit, MSB first.
- eng_ready  in  1  engine accepts command when eng_valid & eng_ready.
- eng_ack_valid  in  1  pulse: ACK bit for last byte sampled.
- eng_nack  in  1  ACK bit value, valid with eng_ack_valid (1 = NACK).

Behaviour:
- Reset values: gnt=0, req_ready=0, req_done=0, req_err=0, eng_valid=0, eng_start=0, eng_stop=0, eng_data=0, state=IDLE, rr pointer=N-1 (so requester 0 wins first), err flag=0, counters=0.
- States:
  - IDLE: if any req, go to ARB. The winner is the first set req bit searching upward from pointer+1, wrapping modulo N. It is registered into the grant index.
  - ARB: gnt driven one-hot. Go to ADDR next cycle.
  - ADDR: eng_valid=1, eng_start=1, eng_data=SLAVE_ADDR. On handshake go to ACK_A.
  - ACK_A: wait for eng_ack_valid. NACK sets err and goes to STOP. ACK goes to DATA.
  - DATA: eng_valid=req_valid[g], eng_data=req byte g, req_ready[g]=eng_ready, all other req_ready=0. On handshake, latch req_last[g] and go to ACK_D.
  - ACK_D: on eng_ack_valid, NACK sets err and goes to STOP. ACK with latched last goes to STOP. ACK without last goes to DATA.
  - STOP: eng_valid=1, eng_stop=1, eng_start=0. On handshake pulse req_done[g] (err=0) or req_err[g] (err=1) in the next cycle, advance pointer to g, then go to GAP.
  - GAP: count GAP_CYC cycles, then clear gnt and err and go to IDLE.
- Timeout counter:
  - Clears on every state change.
  - Increments each cycle in DATA, ACK_A and ACK_D.
  - When it equals TIMEOUT, set err and go to STOP; this takes priority over a same-cycle handshake or ack.
- Engine handshake rule: eng_valid and its qualifiers stay stable until eng_ready. eng_start and eng_stop are never both 1. Commands are only issued in ADDR, DATA and STOP.
- eng_ack_valid outside ACK_A/ACK_D is ignored.
- Dropping req mid-transaction has no effect; the transaction ends only by last-ACK, NACK or timeout.
- New req during a transaction or GAP is held off until IDLE. Arbitration is starvation-free: every requester is served within N transactions.
- Exactly one of req_done/req_err pulses per granted transaction.
- Reset asserted mid-transaction returns everything to reset values immediately. No STOP is issued; the engine is reset by the same reset.

Test Plan:
- Req0 only, bytes 0x00,0xAE,0xAF (last on 0xAF), engine always ACKs -> engine sees START+0x7A, 0x00, 0xAE, 0xAF, STOP. req_done[0] pulses once. gnt=01 until 4 cycles after STOP.
- req=2'b11 held high for 4 transactions -> grant order 0,1,0,1. No overlap of gnt bits. Each gets exactly one done pulse per transaction.
- NACK on address byte for req1 -> no req_ready[1] asserted. STOP issued. req_err[1] pulses, req_done[1] stays 0. Next grant goes to req0.
- NACK on the 2nd data byte -> STOP follows immediately and 3rd byte not accepted (req_ready stays 0). req_err pulses.
- Requester holds req_valid=0 in DATA -> abort after exactly TIMEOUT cycles in DATA, then STOP and req_err. A same-cycle ack at the timeout cycle is ignored.
- Assert reset during ACK_D -> all outputs 0 next edge. After release, req0 and req1 both set -> req0 granted first.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C byte engine between N byte-stream requesters.
// Each grant runs START+address, data bytes, STOP; NACK or stall timeout aborts with STOP.
module i2c_bus_arbiter #(
  parameter int         N          = 2,
  parameter logic [7:0] SLAVE_ADDR = 8'h7A,
  parameter int         GAP_CYC    = 4,
  parameter int         TIMEOUT    = 1023
) (
  input  logic           clk2,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   req_done,
  output logic [N-1:0]   req_err,
  output logic           eng_valid,
  output logic           eng_start,
  output logic           eng_stop,
  output logic [7:0]     eng_data,
  input  logic           eng_ready,
  input  logic           eng_ack_valid,
  input  logic           eng_nack
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_ACK_A = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_ACK_D = 3'd5;
  localparam logic [2:0] S_STOP  = 3'd6;
  localparam logic [2:0] S_GAP   = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] gidx_q;
  logic [IW-1:0] ptr_q;
  logic          err_q;
  logic          last_q;
  logic [TW-1:0] tcnt_q;
  logic [GW-1:0] gcnt_q;
  logic [N-1:0]  done_q;
  logic [N-1:0]  errp_q;

  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic [N-1:0]  gidx_oh;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;
  logic          in_wait;
  logic          tmo;
  logic          set_err;

  assign gidx_oh   = N'(1) << gidx_q;
  assign sel_valid = req_valid[gidx_q];
  assign sel_last  = req_last[gidx_q];
  assign sel_data  = req_data[8*gidx_q +: 8];
  assign in_wait   = (state_q == S_ACK_A) || (state_q == S_DATA) || (state_q == S_ACK_D);
  assign tmo       = in_wait && (tcnt_q == TW'(TIMEOUT));

  // Search upward from ptr+1; iterating from the far end lets the nearest request win.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    win_idx = ptr_q;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (req[cand]) win_idx = cand;
    end
  end

  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    case (state_q)
      S_IDLE:  if (|req) state_d = S_ARB;
      S_ARB:   state_d = S_ADDR;
      S_ADDR:  if (eng_ready) state_d = S_ACK_A;
      S_ACK_A: begin
        if (tmo) begin
          state_d = S_STOP;
          set_err = 1'b1;
        end else if (eng_ack_valid) begin
          state_d = eng_nack ? S_STOP : S_DATA;
          set_err = eng_nack;
        end
      end
      S_DATA: begin
        if (tmo) begin
          state_d = S_STOP;
          set_err = 1'b1;
        end else if (sel_valid && eng_ready) begin
          state_d = S_ACK_D;
        end
      end
      S_ACK_D: begin
        if (tmo) begin
          state_d = S_STOP;
          set_err = 1'b1;
        end else if (eng_ack_valid) begin
          if (eng_nack) begin
            state_d = S_STOP;
            set_err = 1'b1;
          end else begin
            state_d = last_q ? S_STOP : S_DATA;
          end
        end
      end
      S_STOP:  if (eng_ready) state_d = S_GAP;
      S_GAP:   if (gcnt_q == GW'(GAP_CYC - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt       = '0;
    req_ready = '0;
    eng_valid = 1'b0;
    eng_start = 1'b0;
    eng_stop  = 1'b0;
    eng_data  = '0;
    if (state_q != S_IDLE) gnt = gidx_oh;
    case (state_q)
      S_ADDR: begin
        eng_valid = 1'b1;
        eng_start = 1'b1;
        eng_data  = SLAVE_ADDR;
      end
      S_DATA: begin
        eng_valid = sel_valid;
        eng_data  = sel_data;
        req_ready = eng_ready ? gidx_oh : '0;
      end
      S_STOP: begin
        eng_valid = 1'b1;
        eng_stop  = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_done = done_q;
  assign req_err  = errp_q;

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      gidx_q  <= '0;
      ptr_q   <= IW'(N - 1);
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
      done_q  <= '0;
      errp_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      done_q  <= '0;
      errp_q  <= '0;

      if (state_q == S_IDLE && |req) gidx_q <= win_idx;
      if (set_err) err_q <= 1'b1;
      if (state_q == S_DATA && state_d == S_ACK_D) last_q <= sel_last;

      // Stall counter restarts on every state change and only runs while waiting.
      if (state_d != state_q || !in_wait) tcnt_q <= '0;
      else                                tcnt_q <= tcnt_q + 1'b1;

      if (state_q == S_GAP && state_d == S_GAP) gcnt_q <= gcnt_q + 1'b1;
      else                                      gcnt_q <= '0;

      if (state_q == S_STOP && eng_ready) begin
        done_q <= err_q ? '0 : gidx_oh;
        errp_q <= err_q ? gidx_oh : '0;
        ptr_q  <= gidx_q;
      end

      if (state_q == S_GAP && state_d == S_IDLE) err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: requester and engine models feed a
// monitor that compares engine commands, grants and completion pulses.
module tb_i2c_bus_arbiter;

  localparam int         NR   = 2;
  localparam int         TMO  = 30;
  localparam int         GAPC = 4;
  localparam logic [7:0] SADR = 8'h7A;

  typedef struct packed {
    logic [7:0] delay;  // 0 = engine never answers
    logic       nack;
  } ack_t;

  logic            clk2 = 1'b0;
  logic            reset;
  logic [NR-1:0]   req, gnt, req_valid, req_last, req_ready, req_done, req_err;
  logic [8*NR-1:0] req_data;
  logic            eng_valid, eng_start, eng_stop, eng_ready, eng_ack_valid, eng_nack;
  logic [7:0]      eng_data;

  always #5 clk2 = ~clk2;

  i2c_bus_arbiter #(
    .N(NR), .SLAVE_ADDR(SADR), .GAP_CYC(GAPC), .TIMEOUT(TMO)
  ) dut (
    .clk2(clk2), .reset(reset),
    .req(req), .gnt(gnt),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .eng_valid(eng_valid), .eng_start(eng_start), .eng_stop(eng_stop),
    .eng_data(eng_data), .eng_ready(eng_ready),
    .eng_ack_valid(eng_ack_valid), .eng_nack(eng_nack)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event did not match any expectation", name);
  endtask

  // Scoreboard queues
  logic [9:0]      exp_cmd[$];   // {start, stop, data}
  logic [NR-1:0]   exp_gnt[$];
  logic [2*NR-1:0] exp_cmp[$];   // {done, err}

  // Requester / engine model state
  logic [8:0] rq [NR][$];        // {last, data}
  logic [NR-1:0] hold_req;
  int   left_at_err [NR];
  int   rr_run [NR];
  int   last_run [NR];
  int   rr_total [NR];
  ack_t ack_plan[$];
  int   ack_cnt;
  logic ack_nack_pend;
  logic throttle;

  // Pre-edge snapshot of the interface, used by all models and the monitor
  logic          cap_ev, cap_er, cap_start, cap_stop;
  logic [7:0]    cap_data;
  logic [NR-1:0] cap_gnt, cap_rready, cap_rvalid, cap_done, cap_err;

  always @(posedge clk2) begin
    cap_ev     <= eng_valid;
    cap_er     <= eng_ready;
    cap_start  <= eng_start;
    cap_stop   <= eng_stop;
    cap_data   <= eng_data;
    cap_gnt    <= gnt;
    cap_rready <= req_ready;
    cap_rvalid <= req_valid;
    cap_done   <= req_done;
    cap_err    <= req_err;
  end

  // Requester model: presents queued bytes, drops the rest of a transaction on error.
  initial begin
    req = '0; req_valid = '0; req_last = '0; req_data = '0; hold_req = '0;
    for (int i = 0; i < NR; i++) left_at_err[i] = -1;
    forever begin
      @(negedge clk2);
      for (int i = 0; i < NR; i++) begin
        if (cap_rready[i] && cap_rvalid[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (cap_err[i]) begin
          left_at_err[i] = rq[i].size();
          rq[i].delete();
        end
        req[i]       = (rq[i].size() > 0) || hold_req[i];
        req_valid[i] = rq[i].size() > 0;
        if (rq[i].size() > 0) {req_last[i], req_data[8*i +: 8]} = rq[i][0];
        else                  {req_last[i], req_data[8*i +: 8]} = 9'h000;
      end
    end
  end

  // Engine model: answers each byte command after a planned delay (default 2 cycles, ACK).
  initial begin
    ack_t a;
    eng_ready = 1'b1; eng_ack_valid = 1'b0; eng_nack = 1'b0;
    ack_cnt = 0; ack_nack_pend = 1'b0; throttle = 1'b0;
    forever begin
      @(negedge clk2);
      eng_ack_valid = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          eng_ack_valid = 1'b1;
          eng_nack      = ack_nack_pend;
        end
      end
      if (cap_ev && cap_er && !cap_stop) begin
        a = '{delay: 8'd2, nack: 1'b0};
        if (ack_plan.size() > 0) a = ack_plan.pop_front();
        ack_cnt       = int'(a.delay);
        ack_nack_pend = a.nack;
      end
      eng_ready = throttle ? ~eng_ready : 1'b1;
    end
  end

  // Monitor
  initial begin
    logic [9:0]    cmd, prev_cmd;
    logic          prev_stall;
    logic [NR-1:0] prev_gnt;
    int            gap_cnt;
    bit            gap_meas;
    prev_stall = 1'b0; prev_cmd = '0; prev_gnt = '0; gap_cnt = 0; gap_meas = 0;
    for (int i = 0; i < NR; i++) begin
      rr_run[i] = 0; last_run[i] = 0; rr_total[i] = 0;
    end
    forever begin
      @(negedge clk2);
      cmd = {cap_start, cap_stop, cap_stop ? 8'h00 : cap_data};
      if (prev_stall) check("cmd_stable_while_stalled", {cap_ev, cmd}, {1'b1, prev_cmd});
      prev_stall = cap_ev && !cap_er;
      prev_cmd   = cmd;

      if (cap_ev && cap_er) begin
        if (exp_cmd.size() == 0) fail("eng_cmd_unexpected");
        else                     check("eng_cmd", cmd, exp_cmd.pop_front());
      end

      if (cap_gnt != prev_gnt) begin
        check("gnt_onehot0", $onehot0(cap_gnt), 1);
        if (cap_gnt != '0) begin
          if (exp_gnt.size() == 0) fail("gnt_unexpected");
          else                     check("gnt", cap_gnt, exp_gnt.pop_front());
        end
      end
      prev_gnt = cap_gnt;

      if (|cap_done || |cap_err) begin
        if (exp_cmp.size() == 0) fail("completion_unexpected");
        else                     check("completion", {cap_done, cap_err}, exp_cmp.pop_front());
      end

      if (gap_meas) begin
        if (cap_gnt != '0) gap_cnt++;
        else begin
          check("gnt_hold_after_stop", gap_cnt, GAPC);
          gap_meas = 0;
        end
      end
      if (cap_ev && cap_er && cap_stop) begin
        gap_meas = 1;
        gap_cnt  = 0;
      end

      for (int i = 0; i < NR; i++) begin
        if (cap_rready[i]) begin
          rr_run[i]++;
          rr_total[i]++;
        end else if (rr_run[i] > 0) begin
          last_run[i] = rr_run[i];
          rr_run[i]   = 0;
        end
      end
    end
  end

  task automatic load(input int r, input int nb, input logic [7:0] b[4]);
    for (int k = 0; k < nb; k++) rq[r].push_back({(k == nb - 1), b[k]});
  endtask

  task automatic exp_txn(input int r, input int nsent, input logic [7:0] b[4], input bit ok);
    logic [NR-1:0] oh;
    oh = NR'(1) << r;
    exp_gnt.push_back(oh);
    exp_cmd.push_back({2'b10, SADR});
    for (int k = 0; k < nsent; k++) exp_cmd.push_back({2'b00, b[k]});
    exp_cmd.push_back({2'b01, 8'h00});
    exp_cmp.push_back(ok ? {oh, NR'(0)} : {NR'(0), oh});
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_cmd.size() > 0 || exp_gnt.size() > 0 || exp_cmp.size() > 0 ||
            gnt != '0 || req != '0) && n < budget) begin
      @(negedge clk2); #2;
      n++;
    end
    if (n >= budget) fail({name, "_cycle_budget"});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_req_done"}, req_done, 0);
    check({tag, "_req_err"}, req_err, 0);
    check({tag, "_eng_ctl"}, {eng_valid, eng_start, eng_stop}, 0);
    check({tag, "_eng_data"}, eng_data, 0);
  endtask

  initial begin
    int n;
    int rr_before;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk2);
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk2);
    #2;

    // Single requester, three bytes, all ACKed
    load(0, 3, '{8'h00, 8'hAE, 8'hAF, 8'h00});
    exp_txn(0, 3, '{8'h00, 8'hAE, 8'hAF, 8'h00}, 1);
    wait_quiet("single_txn", 200);

    // Address NACK for requester 1: no byte ever offered to it
    rr_before = rr_total[1];
    ack_plan.push_back('{delay: 8'd2, nack: 1'b1});
    load(1, 2, '{8'h10, 8'h20, 8'h00, 8'h00});
    exp_txn(1, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 0);
    wait_quiet("addr_nack", 200);
    check("addr_nack_no_ready", rr_total[1] - rr_before, 0);

    // Both request for four transactions, with engine backpressure: order 0,1,0,1
    throttle = 1'b1;
    load(0, 2, '{8'h01, 8'h02, 8'h00, 8'h00});
    load(0, 3, '{8'h03, 8'h04, 8'h05, 8'h00});
    load(1, 1, '{8'h81, 8'h00, 8'h00, 8'h00});
    load(1, 2, '{8'h82, 8'h83, 8'h00, 8'h00});
    exp_txn(0, 2, '{8'h01, 8'h02, 8'h00, 8'h00}, 1);
    exp_txn(1, 1, '{8'h81, 8'h00, 8'h00, 8'h00}, 1);
    exp_txn(0, 3, '{8'h03, 8'h04, 8'h05, 8'h00}, 1);
    exp_txn(1, 2, '{8'h82, 8'h83, 8'h00, 8'h00}, 1);
    wait_quiet("round_robin", 800);
    throttle = 1'b0;
    @(negedge clk2); #2;

    // NACK on second data byte: third byte must stay with the requester
    left_at_err[0] = -1;
    ack_plan.push_back('{delay: 8'd2, nack: 1'b0});
    ack_plan.push_back('{delay: 8'd2, nack: 1'b0});
    ack_plan.push_back('{delay: 8'd2, nack: 1'b1});
    load(0, 3, '{8'hC1, 8'hC2, 8'hC3, 8'h00});
    exp_txn(0, 2, '{8'hC1, 8'hC2, 8'h00, 8'h00}, 0);
    wait_quiet("data_nack", 200);
    check("data_nack_bytes_left", left_at_err[0], 1);

    // Requester 1 never supplies a byte; req dropped once granted
    hold_req[1] = 1'b1;
    exp_txn(1, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 0);
    n = 0;
    while (!gnt[1] && n < 50) begin
      @(negedge clk2); #2;
      n++;
    end
    if (n >= 50) fail("data_timeout_grant_budget");
    hold_req[1] = 1'b0;
    wait_quiet("data_timeout", 300);
    // Counter runs 0..TMO while in DATA; the abort is taken in the cycle it reaches TMO
    check("data_timeout_cycles", last_run[1], TMO + 1);

    // ACK_D timeout where the ACK lands in exactly the timeout cycle: abort wins
    left_at_err[0] = -1;
    ack_plan.push_back('{delay: 8'd2, nack: 1'b0});
    ack_plan.push_back('{delay: 8'(TMO), nack: 1'b0});
    load(0, 2, '{8'h55, 8'h66, 8'h00, 8'h00});
    exp_txn(0, 1, '{8'h55, 8'h00, 8'h00, 8'h00}, 0);
    wait_quiet("ackd_timeout", 300);
    check("ackd_timeout_bytes_left", left_at_err[0], 1);

    // Reset while waiting in ACK_D
    ack_plan.push_back('{delay: 8'd2, nack: 1'b0});
    ack_plan.push_back('{delay: 8'd0, nack: 1'b0});
    load(0, 2, '{8'h11, 8'h22, 8'h00, 8'h00});
    exp_gnt.push_back(2'b01);
    exp_cmd.push_back({2'b10, SADR});
    exp_cmd.push_back({2'b00, 8'h11});
    n = 0;
    while (exp_cmd.size() > 0 && n < 100) begin
      @(negedge clk2); #2;
      n++;
    end
    if (n >= 100) fail("reset_setup_budget");
    reset = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    for (int i = 0; i < NR; i++) rq[i].delete();
    hold_req = '0;
    ack_plan.delete();
    ack_cnt = 0;
    @(negedge clk2);
    @(negedge clk2);
    check("mid_reset_held_gnt", gnt, 0);
    reset = 1'b1;
    @(negedge clk2); #2;

    // After reset requester 0 wins first again
    load(0, 1, '{8'h31, 8'h00, 8'h00, 8'h00});
    load(1, 1, '{8'h42, 8'h00, 8'h00, 8'h00});
    exp_txn(0, 1, '{8'h31, 8'h00, 8'h00, 8'h00}, 1);
    exp_txn(1, 1, '{8'h42, 8'h00, 8'h00, 8'h00}, 1);
    wait_quiet("post_reset", 300);

    repeat (4) @(negedge clk2);
    check("leftover_cmds", exp_cmd.size(), 0);
    check("leftover_completions", exp_cmp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
